// File: rtl/sub_top_nios2_qsys_0_oci_trace_capture.sv
// OCI data-capture-trace unpacker: packed DCT buffers into a circular capture memory, drained via rd port.
// Define OCI_TRACE_STOP_ON_FULL_EN to drop entries when full instead of overwriting the oldest (default).
module sub_top_nios2_qsys_0_oci_trace_capture #(
  parameter int ENTRY_W         = 10,
  parameter int ENTRIES_PER_BUF = 3,
  parameter int DEPTH           = 16,
  parameter int CNT_W           = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [ENTRY_W*ENTRIES_PER_BUF-1:0] dct_buffer,
  input  logic [CNT_W-1:0]                   dct_count,
  input  logic                               dct_load,
  input  logic                               test_ending,
  input  logic                               test_has_ended,
  input  logic                               rd_req,
  output logic [ENTRY_W-1:0]                 rd_data,
  output logic                               rd_valid,
  output logic [$clog2(DEPTH):0]             level,
  output logic [15:0]                        overflow_cnt,
  output logic [1:0]                         state,
  output logic                               done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d, lvl_pop;
  logic [15:0]        ovf_q, ovf_d;
  logic [16:0]        ovf_sum;
  logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               pop, load_ok;
  int unsigned        n_eff, free_sp, n_wr, lost;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_comb begin
    pop     = rd_req && (level_q != '0);
    lvl_pop = level_q - LVL_W'(pop);
    load_ok = dct_load && !test_has_ended && (state_q == ST_IDLE || state_q == ST_CAPTURE);
    n_eff   = 0;
    if (load_ok) begin
      n_eff = (32'(dct_count) > ENTRIES_PER_BUF) ? ENTRIES_PER_BUF : 32'(dct_count);
    end
    // Free space is measured after this cycle's pop has released its slot.
    free_sp = DEPTH - 32'(lvl_pop);
`ifdef OCI_TRACE_STOP_ON_FULL_EN
    n_wr     = (n_eff > free_sp) ? free_sp : n_eff;
    lost     = n_eff - n_wr;
    level_d  = LVL_W'(32'(lvl_pop) + n_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
`else
    n_wr     = n_eff;
    lost     = (n_eff > free_sp) ? (n_eff - free_sp) : 0;
    level_d  = LVL_W'(32'(lvl_pop) + n_wr - lost);
    // Overwritten entries are skipped by the reader so the oldest survivor comes out next.
    rd_ptr_d = rd_ptr_q + PTR_W'(pop) + PTR_W'(lost);
`endif
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_wr);
    ovf_sum    = {1'b0, ovf_q} + 17'(lost);
    ovf_d      = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop;

    state_d = state_q;
    if (test_has_ended) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE:    if (dct_load) state_d = ST_CAPTURE;
        ST_CAPTURE: if (test_ending) state_d = ST_DRAIN;
        ST_DRAIN:   if (level_q == '0) state_d = ST_DONE;
        default:    state_d = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES_PER_BUF; i++) begin
      if (n_wr > 32'(i)) begin
        mem_q[wr_ptr_q + PTR_W'(i)] <= dct_buffer[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign level        = level_q;
  assign overflow_cnt = ovf_q;
  assign state        = state_q;
  assign done         = (state_q == ST_DONE);
endmodule

// File: tb/tb_sub_top_nios2_qsys_0_oci_trace_capture.sv
// Directed self-checking bench for the OCI trace capture block (default parameters).
module tb_sub_top_nios2_qsys_0_oci_trace_capture;
`ifdef OCI_TRACE_STOP_ON_FULL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_load, test_ending, test_has_ended, rd_req;
  logic [9:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic [15:0] overflow_cnt;
  logic [1:0]  state;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] vals [16];

  sub_top_nios2_qsys_0_oci_trace_capture dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_load(dct_load), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .overflow_cnt(overflow_cnt), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [9:0] e2, input logic [9:0] e1, input logic [9:0] e0,
                      input logic [3:0] cnt);
    dct_buffer = {e2, e1, e0};
    dct_count  = cnt;
    dct_load   = 1'b1;
    tick();
    dct_load   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; dct_buffer = '0; dct_count = '0; dct_load = 1'b0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_req = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow_cnt), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_done", 32'(done), 0);
    reset_n = 1'b1;
    tick();

    // basic capture and ordered readout
    load(10'h003, 10'h002, 10'h001, 4'd3);
    chk("cap_state", 32'(state), 1);
    chk("cap_level", 32'(level), 3);
    rd_req = 1'b1;
    tick();
    chk("rd0_valid", 32'(rd_valid), 1);
    chk("rd0_data", 32'(rd_data), 32'h001);
    tick();
    chk("rd1_data", 32'(rd_data), 32'h002);
    tick();
    chk("rd2_data", 32'(rd_data), 32'h003);
    chk("rd_level0", 32'(level), 0);
    tick();
    chk("rd_empty_valid", 32'(rd_valid), 0);
    rd_req = 1'b0;

    // count clamp: 7 -> 3
    load(10'h006, 10'h005, 10'h004, 4'd7);
    chk("clamp_level", 32'(level), 3);
    rd_req = 1'b1;
    tick(); chk("clamp_rd0", 32'(rd_data), 32'h004);
    tick(); tick();
    chk("clamp_rd2", 32'(rd_data), 32'h006);
    rd_req = 1'b0;
    tick();

    // full boundary: values 1..18
    for (int k = 0; k < 6; k++) begin
      load(10'(3*k+3), 10'(3*k+2), 10'(3*k+1), 4'd3);
      if (k == 4) chk("fill_level15", 32'(level), 15);
    end
    chk("full_level", 32'(level), 16);
    chk("full_ovf", 32'(overflow_cnt), 2);

    // pop and 1-entry load at full
    rd_req = 1'b1;
    load(10'h000, 10'h000, 10'h0AA, 4'd1);
    chk("simul_valid", 32'(rd_valid), 1);
    chk("simul_data", 32'(rd_data), STOP ? 32'd1 : 32'd3);
    chk("simul_level", 32'(level), 16);
    chk("simul_ovf", 32'(overflow_cnt), 2);
    for (int i = 0; i < 16; i++) begin
      tick();
      vals[i] = rd_data;
    end
    rd_req = 1'b0;
    chk("drain_first", 32'(vals[0]), STOP ? 32'd2 : 32'd4);
    chk("drain_15th", 32'(vals[14]), STOP ? 32'd16 : 32'd18);
    chk("drain_last", 32'(vals[15]), 32'h0AA);
    chk("drain_level", 32'(level), 0);
    tick();

    // end sequencing through DRAIN
    load(10'h000, 10'h012, 10'h011, 4'd2);
    chk("end_level2", 32'(level), 2);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    chk("end_drain", 32'(state), 2);
    load(10'h033, 10'h032, 10'h031, 4'd3);
    chk("drain_ignore_level", 32'(level), 2);
    chk("drain_ignore_ovf", 32'(overflow_cnt), 2);
    rd_req = 1'b1;
    tick(); chk("end_rd0", 32'(rd_data), 32'h011);
    tick(); chk("end_rd1", 32'(rd_data), 32'h012);
    chk("end_still_drain", 32'(state), 2);
    rd_req = 1'b0;
    tick();
    chk("end_done_state", 32'(state), 3);
    chk("end_done", 32'(done), 1);
    tick();
    chk("done_sticky", 32'(state), 3);

    // test_has_ended from CAPTURE discards same-cycle load
    do_reset();
    load(10'h000, 10'h000, 10'h041, 4'd1);
    chk("the_cap", 32'(state), 1);
    test_has_ended = 1'b1;
    load(10'h044, 10'h043, 10'h042, 4'd3);
    test_has_ended = 1'b0;
    chk("the_state", 32'(state), 3);
    chk("the_done", 32'(done), 1);
    chk("the_level", 32'(level), 1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("the_rd_valid", 32'(rd_valid), 1);
    chk("the_rd_data", 32'(rd_data), 32'h041);

    // asynchronous reset while draining with level 5
    do_reset();
    load(10'h023, 10'h022, 10'h021, 4'd3);
    load(10'h026, 10'h025, 10'h024, 4'd3);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    chk("pre_rst_state", 32'(state), 2);
    chk("pre_rst_level", 32'(level), 5);
    chk("pre_rst_data", 32'(rd_data), 32'h021);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_ovf", 32'(overflow_cnt), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sub_top_nios2_qsys_0_oci_trace_capture.md
# sub_top_nios2_qsys_0_oci_trace_capture

Parametrised successor to the OCI debug test bench. It unpacks data-capture-trace (DCT) buffers from the Nios II OCI into a circular capture memory, and drains them through a simple read port. It also tracks end-of-test sequencing and counts lost entries. It sits beside the OCI in the `sub_top` simulation/debug path, and software-visible readout goes through the rd port.

## Interface
Parameters:
- `ENTRY_W`, 10, width of one trace entry
- `ENTRIES_PER_BUF`, 3, entries packed per DCT buffer (entry 0 in the LSBs)
- `DEPTH`, 16, capture memory entries; a power of two, at least 4
- `CNT_W`, 4, width of `dct_count`

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `dct_buffer` in ENTRY_W*ENTRIES_PER_BUF: packed trace entries.
- `dct_count` in CNT_W: number of valid entries, taken from entry 0 upward.
- `dct_load` in 1: one-cycle strobe qualifying `dct_buffer`/`dct_count`.
- `test_ending` in 1: level; request to stop capture.
- `test_has_ended` in 1: level; forces DONE.
- `rd_req` in 1: pops the oldest entry.
- `rd_data` out ENTRY_W: popped entry.
- `rd_valid` out 1: one-cycle qualifier for `rd_data`.
- `level` out $clog2(DEPTH)+1: entries currently held.
- `overflow_cnt` out 16: lost entries, saturating at 16'hFFFF.
- `state` out 2: 0 = IDLE, 1 = CAPTURE, 2 = DRAIN, 3 = DONE.
- `done` out 1: high exactly when the state is DONE.

## Operation
- Reset values: state IDLE; `level`, `overflow_cnt`, `rd_data`, `rd_valid`, `done` all 0; read and write pointers 0.
- Effective count n = min(`dct_count`, ENTRIES_PER_BUF). A count of 0 is a no-op but still counts as a load for leaving IDLE.
- IDLE -> CAPTURE on `dct_load`. That same load is captured.
- CAPTURE -> DRAIN on `test_ending`. A `dct_load` in the same cycle is still captured.
- DRAIN:
  - `dct_load` is ignored and does not count as overflow.
  - DRAIN -> DONE when `level` = 0 and no read is outstanding.
- Any state -> DONE on `test_has_ended`. This has priority over all other transitions.
  - A load in that cycle is discarded.
- DONE is sticky until reset. Reads remain serviced in DONE.
- Capture writes all n entries in one cycle, at consecutive write-pointer slots in entry order. Pointers wrap modulo DEPTH.
- Read: `rd_req` with `level` > 0 pops the oldest entry. With `level` = 0, `rd_req` is ignored and `rd_valid` stays low.
- Simultaneous read and load: the read is applied first, using the pre-write oldest entry and freeing a slot. The writes follow.
  - Net `level` = old level - pop + written.
- Free space is computed after the same-cycle pop. Entries beyond free space are handled per Configuration. `overflow_cnt` adds the number of lost entries and saturates.

## Timing
- `rd_data`/`rd_valid` are registered and appear 1 cycle after an accepted `rd_req`. Back-to-back reads sustain 1 entry/cycle.
- `level`, `overflow_cnt`, `state` and `done` are registered and update 1 cycle after the causing edge.
- Reset assertion mid-operation clears all state asynchronously. Memory contents need not be cleared.
- No combinational path from inputs to outputs.

## Configuration
- `OCI_TRACE_STOP_ON_FULL_EN` defined (stop-on-full):
  - Entries that do not fit are dropped and counted.
  - Stored entries are never overwritten.
- Not defined (wrap mode, default):
  - Excess entries overwrite the oldest entries.
  - The read pointer advances past each overwritten entry, and `level` stays at DEPTH.
  - `overflow_cnt` counts overwritten entries.

## Test plan
- **Reset, then basic capture and read.** Reset, then load count 3 with entries 0x001/0x002/0x003.
  - Required: `state` = 1 and `level` = 3.
  - Then 3 reads return 0x001, 0x002, 0x003 in order, each with `rd_valid` 1 cycle after its request; `level` ends at 0.
- **Count clamp and zero count.** Load with `dct_count` = 7.
  - Required: 3 entries stored.
  - A load with `dct_count` = 0 in IDLE moves to CAPTURE with `level` = 0.
- **Full boundary, DEPTH = 16.** Six loads of 3 entries (values 1..18).
  - Wrap mode required: `level` = 16, `overflow_cnt` = 2, first read = 3.
  - With `OCI_TRACE_STOP_ON_FULL_EN` required: `overflow_cnt` = 2, first read = 1, last read = 16.
- **Simultaneous pop and load at full.** Full at 16; `rd_req` plus a 1-entry load in the same cycle.
  - Required: the oldest entry is returned, `level` stays 16, `overflow_cnt` is unchanged.
- **End sequencing.**
  - `test_ending` with 2 entries held: DRAIN; later loads are ignored; 2 reads give DONE with `done` = 1.
  - `test_has_ended` from CAPTURE: DONE next cycle, with the same-cycle load discarded.
- **Reset mid-operation.** Assert `reset_n` low while in DRAIN with `level` = 5.
  - Required: all outputs return to their reset values immediately, with no clock edge.
